// File: rtl/action_pkg.sv
// Shared widths, FSM state type and the wrap-around next-code rule for the
// action decoder.
package action_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Successor of c in the sequence 0..last, wrapping last -> 0.
  function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] c,
                                                  input logic [CODE_W-1:0] last);
    return (c == last) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/action_sync.sv
// Parameterized-width two-flop synchronizer; used for the ripple counter bus
// when ACTION_DECODER_SYNC_EN is defined.
module action_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/action_decoder.sv
// Action-code receiver: change detect, sequence tracking and a one-hot strobe
// over valid/ready. Define ACTION_DECODER_SYNC_EN to synchronize code_in first.
module action_decoder
  import action_pkg::*;
#(
  parameter int NUM_CODES = 4,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CODE_W-1:0]    code_in,
  input  logic                 act_ready,
  input  logic                 clr_err,
  output logic                 act_valid,
  output logic [ONEHOT_W-1:0]  act_onehot,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [CODE_W:0]      LP_NUM  = NUM_CODES[CODE_W:0];
  localparam logic [CODE_W-1:0]    LP_LAST = CODE_W'(NUM_CODES - 1);
  localparam logic [ERR_CNT_W-1:0] LP_MAX  = '1;
  localparam logic [ONEHOT_W-1:0]  LP_ONE  = ONEHOT_W'(1);

  logic [CODE_W-1:0] w_code;

`ifdef ACTION_DECODER_SYNC_EN
  action_sync #(.WIDTH(CODE_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (code_in),
    .o_q (w_code)
  );
`else
  assign w_code = code_in;
`endif

  state_t            r_state;
  logic [CODE_W-1:0] r_prev;
  logic [CODE_W-1:0] r_exp;
  logic              r_first;

  logic w_event;
  logic w_legal;
  logic w_free;
  logic w_accept;
  logic w_err;

  // NOTE: every output of this block is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_event  = r_first || (w_code != r_prev);
    w_legal  = {1'b0, w_code} < LP_NUM;
    w_free   = !act_valid || act_ready;
    w_accept = 1'b0;
    w_err    = 1'b0;
    if (w_event) begin
      if (!w_legal || !w_free) begin
        w_err = 1'b1;
      end else begin
        w_accept = 1'b1;
        w_err    = (r_state == TRACK) && (w_code != r_exp);
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prev     <= '0;
      r_exp      <= '0;
      r_first    <= 1'b1;
      act_valid  <= 1'b0;
      act_onehot <= '0;
      seq_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      r_prev  <= w_code;
      r_first <= 1'b0;

      // Out-of-range codes drop tracking even when the slot is busy.
      if (w_event && !w_legal) begin
        r_state <= IDLE;
      end else if (w_accept) begin
        r_state <= TRACK;
        r_exp   <= next_code(w_code, LP_LAST);
      end

      if (w_accept) begin
        act_valid  <= 1'b1;
        act_onehot <= LP_ONE << w_code;
      end else if (act_ready) begin
        act_valid  <= 1'b0;
      end

      if (w_err) begin
        seq_err   <= 1'b1;
        err_count <= clr_err ? ERR_CNT_W'(1)
                   : (err_count == LP_MAX) ? LP_MAX : err_count + 1'b1;
      end else if (clr_err) begin
        seq_err   <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_action_decoder.sv
// Self-checking bench for action_decoder: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the decoder.
module tb_action_decoder;

  localparam int NUM_CODES = 4;
  localparam int ERR_CNT_W = 4;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef ACTION_DECODER_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           code_in = '0;
  logic                 act_ready = 1'b1;
  logic                 clr_err = 1'b0;
  logic                 act_valid;
  logic [7:0]           act_onehot;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_count;

  action_decoder #(.NUM_CODES(NUM_CODES), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .act_ready  (act_ready),
    .clr_err    (clr_err),
    .act_valid  (act_valid),
    .act_onehot (act_onehot),
    .seq_err    (seq_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the consumer should observe, in plain integers.
  int m_prev, m_exp, m_onehot, m_cnt;
  bit m_first, m_tracking, m_valid, m_seq;
  int m_pipe[$];

  task automatic model_reset();
    m_prev = 0; m_exp = 0; m_onehot = 0; m_cnt = 0;
    m_first = 1; m_tracking = 0; m_valid = 0; m_seq = 0;
    m_pipe.delete();
    for (int i = 0; i < SYNC_DEPTH; i++) m_pipe.push_back(0);
  endtask

  task automatic model_cycle(input int code, input bit rdy, input bit clr);
    int  cur;
    bit  ev, err, acc;
    if (SYNC_DEPTH > 0) begin
      cur = m_pipe.pop_front();
      m_pipe.push_back(code);
    end else begin
      cur = code;
    end
    ev  = m_first || (cur != m_prev);
    err = 0;
    acc = 0;
    if (ev) begin
      if (cur >= NUM_CODES) begin
        err = 1;
        m_tracking = 0;
      end else if (m_valid && !rdy) begin
        err = 1;
      end else begin
        acc = 1;
        if (m_tracking && cur != m_exp) err = 1;
        m_exp = (cur + 1) % NUM_CODES;
        m_tracking = 1;
      end
    end
    if (acc) begin
      m_valid  = 1;
      m_onehot = 1 << cur;
    end else if (rdy) begin
      m_valid = 0;
    end
    if (err) begin
      m_seq = 1;
      m_cnt = clr ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
    end else if (clr) begin
      m_seq = 0;
      m_cnt = 0;
    end
    m_prev  = cur;
    m_first = 0;
  endtask

  task automatic compare(input string where);
    check({where, ".valid"}, act_valid, m_valid);
    check({where, ".seq_err"}, seq_err, m_seq);
    check({where, ".err_count"}, err_count, m_cnt);
    if (m_valid) check({where, ".onehot"}, act_onehot, m_onehot);
  endtask

  // Called and returning at a falling edge; one rising edge per call.
  task automatic step(input int c, input bit rdy, input bit clr, input string where);
    code_in   = 3'(c);
    act_ready = rdy;
    clr_err   = clr;
    @(posedge clk);
    model_cycle(c, rdy, clr);
    #1 compare(where);
    @(negedge clk);
  endtask

  task automatic do_reset(input string where);
    rst = 1'b1;
    #1;
    check({where, ".async_valid"}, act_valid, 0);
    check({where, ".async_onehot"}, act_onehot, 0);
    model_reset();
    compare(where);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic settle(input int c, input string where);
    for (int i = 0; i < SYNC_DEPTH + 2; i++) step(c, 1, 0, where);
  endtask

  initial begin
    int c;
    model_reset();
    @(negedge clk);
    do_reset("reset");

    // Legal wrap-around sequence, two cycles per code.
    for (int i = 0; i < 5; i++) begin
      step(i % NUM_CODES, 1, 0, "seq");
      step(i % NUM_CODES, 1, 0, "seq");
    end
    settle(0, "seq_tail");
    check("seq.no_err", err_count, 0);

    // Jump 1 -> 3 resyncs, then 0 follows cleanly.
    step(1, 1, 0, "jump");
    step(3, 1, 0, "jump");
    step(0, 1, 0, "jump");
    settle(0, "jump_tail");
    check("jump.err_count", err_count, 1);

    // Out-of-range code, then a fresh start from 2.
    do_reset("oor_reset");
    step(0, 1, 0, "oor");
    step(6, 1, 0, "oor");
    step(2, 1, 0, "oor");
    settle(2, "oor_tail");
    check("oor.err_count", err_count, 1);
    check("oor.onehot", act_onehot, 8'h04);

    // Backpressure drops a code; later accept sees sequence error.
    do_reset("bp_reset");
    step(0, 0, 0, "bp");
    for (int i = 0; i < SYNC_DEPTH + 1; i++) step(0, 0, 0, "bp_hold");
    step(1, 0, 0, "bp");
    for (int i = 0; i < SYNC_DEPTH + 1; i++) step(1, 0, 0, "bp_hold");
    check("bp.onehot_held", act_onehot, 8'h01);
    step(2, 1, 0, "bp");
    settle(2, "bp_tail");
    check("bp.err_count", err_count, 2);

    // Saturation, then clear coincident with a new error.
    for (int i = 0; i < 20; i++) step(6 + (i % 2), 1, 0, "sat");
    settle(7, "sat_tail");
    check("sat.err_count", err_count, CNT_MAX);
    for (int i = 0; i < SYNC_DEPTH; i++) step(6, 1, 0, "clr_pre");
    step(6, 1, 1, "clr");
    check("clr.err_count", err_count, 1);
    check("clr.seq_err", seq_err, 1);
    step(6, 1, 1, "clr_only");

    // Reset while a strobe is pending.
    step(0, 0, 0, "pend");
    settle(0, "pend");
    do_reset("pend_reset");

    // Random traffic with occasional clears and resets.
    c = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r >= 7)      c = $urandom_range(0, 7);
      else if (r >= 4) c = (c + 1) % NUM_CODES;
      step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, "rand");
      if ($urandom_range(0, 299) == 0) do_reset("rand_reset");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
